// File: rtl/cfi_pkg.sv
// Shared types and flag encodings for the CFI commit-log queue.
package cfi_pkg;

    localparam int unsigned VLEN = 64;

    localparam logic [3:0] CFI_FLAG_BRANCH = 4'b1000;
    localparam logic [3:0] CFI_FLAG_JUMP   = 4'b0100;
    localparam logic [3:0] CFI_FLAG_CALL   = 4'b0010;
    localparam logic [3:0] CFI_FLAG_RETURN = 4'b0001;

    typedef struct packed {
        logic [VLEN-1:0] pc;
        logic [VLEN-1:0] target;
        logic [3:0]      flags;
    } cfi_commit_log_t;

endpackage

// File: rtl/cfi_log_fifo.sv
// Synchronous FIFO of CFI log records; head is read combinationally from storage.
module cfi_log_fifo
    import cfi_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            push_i,
    input  cfi_commit_log_t data_i,
    input  logic            pop_i,
    output cfi_commit_log_t data_o,
    output logic            full_o,
    output logic            empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    cfi_commit_log_t mem_q [DEPTH];
    cfi_commit_log_t mem_d [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push_ok;
    logic            pop_ok;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign pop_ok  = pop_i & ~empty_o & ~flush_i;
    assign push_ok = push_i & (~full_o | pop_ok) & ~flush_i;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = wr_ptr_q + PtrW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/cfi_log_frontend.sv
// Classifies committed CFI instructions and queues one log record per instruction.
module cfi_log_frontend
    import cfi_pkg::*;
#(
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned STALL_ON_FULL = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            commit_valid_i,
    input  logic [VLEN-1:0] commit_pc_i,
    input  logic [VLEN-1:0] commit_target_i,
    input  logic            is_branch_i,
    input  logic            is_jump_i,
    input  logic            is_call_i,
    input  logic            is_return_i,
    output logic            stall_o,
    output cfi_commit_log_t log_o,
    output logic            queue_empty_o,
    input  logic            queue_pop_i,
    output logic [31:0]     dropped_o
);

    logic [3:0]      flags;
    logic            cfi_commit;
    logic            can_push;
    logic            push;
    logic            drop;
    logic            fifo_full;
    cfi_commit_log_t rec;
    logic [31:0]     dropped_q, dropped_d;

    // Priority order matters: a call that also looks like a return is a call.
    always_comb begin
        flags = 4'b0000;
        if (is_call_i) begin
            flags = CFI_FLAG_CALL;
        end else if (is_return_i) begin
            flags = CFI_FLAG_RETURN;
        end else if (is_jump_i) begin
            flags = CFI_FLAG_JUMP;
        end else if (is_branch_i) begin
            flags = CFI_FLAG_BRANCH;
        end
    end

    assign cfi_commit = commit_valid_i & (|flags);
    assign can_push   = ~fifo_full | (queue_pop_i & ~queue_empty_o);

    always_comb begin
        stall_o = 1'b0;
        drop    = 1'b0;
        if (STALL_ON_FULL != 0) begin
            stall_o = cfi_commit & ~can_push & ~flush_i & ~rst_i;
        end else begin
            drop = cfi_commit & ~can_push;
        end
    end

    assign push       = cfi_commit & can_push & ~stall_o & ~flush_i;
    assign rec.pc     = commit_pc_i;
    assign rec.target = commit_target_i;
    assign rec.flags  = flags;

    always_comb begin
        dropped_d = dropped_q;
        if (drop && (dropped_q != 32'hFFFF_FFFF)) begin
            dropped_d = dropped_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dropped_q <= '0;
        end else begin
            dropped_q <= dropped_d;
        end
    end

    assign dropped_o = dropped_q;

    cfi_log_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (push),
        .data_i  (rec),
        .pop_i   (queue_pop_i),
        .data_o  (log_o),
        .full_o  (fifo_full),
        .empty_o (queue_empty_o)
    );

endmodule

// File: tb/tb_cfi_log_frontend.sv
// Directed bench: a stalling instance and a dropping instance driven by shared stimulus.
module tb_cfi_log_frontend;
    import cfi_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            cvalid;
    logic [VLEN-1:0] cpc;
    logic [VLEN-1:0] ctgt;
    logic            br, jmp, call, ret;
    logic            pop;

    logic            stall_s, empty_s;
    cfi_commit_log_t log_s;
    logic [31:0]     dropped_s;
    logic            stall_d, empty_d;
    cfi_commit_log_t log_d;
    logic [31:0]     dropped_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cfi_log_frontend #(
        .DEPTH         (8),
        .STALL_ON_FULL (1)
    ) u_dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .flush_i         (flush),
        .commit_valid_i  (cvalid),
        .commit_pc_i     (cpc),
        .commit_target_i (ctgt),
        .is_branch_i     (br),
        .is_jump_i       (jmp),
        .is_call_i       (call),
        .is_return_i     (ret),
        .stall_o         (stall_s),
        .log_o           (log_s),
        .queue_empty_o   (empty_s),
        .queue_pop_i     (pop),
        .dropped_o       (dropped_s)
    );

    cfi_log_frontend #(
        .DEPTH         (8),
        .STALL_ON_FULL (0)
    ) u_drop (
        .clk_i           (clk),
        .rst_i           (rst),
        .flush_i         (flush),
        .commit_valid_i  (cvalid),
        .commit_pc_i     (cpc),
        .commit_target_i (ctgt),
        .is_branch_i     (br),
        .is_jump_i       (jmp),
        .is_call_i       (call),
        .is_return_i     (ret),
        .stall_o         (stall_d),
        .log_o           (log_d),
        .queue_empty_o   (empty_d),
        .queue_pop_i     (pop),
        .dropped_o       (dropped_d)
    );

    // kind: 0 none, 1 branch, 2 jump, 3 call, 4 return, 5 call+return
    task automatic set_commit(input logic v, input int kind, input logic [VLEN-1:0] pc,
                              input logic [VLEN-1:0] tgt);
        cvalid = v;
        cpc    = pc;
        ctgt   = tgt;
        br     = (kind == 1);
        jmp    = (kind == 2);
        call   = (kind == 3) || (kind == 5);
        ret    = (kind == 4) || (kind == 5);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        flush = 1'b0;
        pop   = 1'b0;
        set_commit(1'b0, 0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (empty_s !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty_s); end
        checks++; if (stall_s !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall_s); end
        checks++; if (log_s !== '0) begin errors++; $display("FAIL reset_log got %h exp 0", log_s); end
        checks++; if (dropped_d !== 32'd0) begin errors++; $display("FAIL reset_dropped got %0d exp 0", dropped_d); end
    endtask

    task automatic test_branch();
        do_reset();
        set_commit(1'b1, 1, 64'h1000, 64'h1040);
        @(negedge clk);
        set_commit(1'b0, 0, '0, '0);
        checks++; if (empty_s !== 1'b0) begin errors++; $display("FAIL branch_nonempty got %b exp 0", empty_s); end
        checks++;
        if (log_s.pc !== 64'h1000 || log_s.target !== 64'h1040 || log_s.flags !== 4'b1000) begin
            errors++;
            $display("FAIL branch_record got %h/%h/%b exp 1000/1040/1000", log_s.pc, log_s.target,
                     log_s.flags);
        end
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        checks++; if (empty_s !== 1'b1) begin errors++; $display("FAIL branch_pop_empty got %b exp 1", empty_s); end
    endtask

    task automatic test_priority();
        do_reset();
        set_commit(1'b1, 5, 64'h2000, 64'h2100);
        @(negedge clk);
        checks++; if (log_s.flags !== 4'b0010 || log_s.pc !== 64'h2000) begin
            errors++; $display("FAIL call_over_return got %b/%h exp 0010/2000", log_s.flags, log_s.pc);
        end
        // Pop the call while a flagless commit arrives: it must not enter the queue.
        set_commit(1'b1, 0, 64'h3000, 64'h3004);
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        set_commit(1'b0, 0, '0, '0);
        checks++; if (empty_s !== 1'b1) begin errors++; $display("FAIL non_cfi_push got empty=%b exp 1", empty_s); end
    endtask

    task automatic test_full_stall();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_commit(1'b1, 2, 64'(i), 64'(i + 4));
            #1;
            checks++; if (stall_s !== 1'b0) begin errors++; $display("FAIL fill_stall[%0d] got %b exp 0", i, stall_s); end
            @(negedge clk);
        end
        set_commit(1'b1, 2, 64'd8, 64'd12);
        #1;
        checks++; if (stall_s !== 1'b1) begin errors++; $display("FAIL ninth_stall got %b exp 1", stall_s); end
        @(negedge clk);
        checks++; if (stall_s !== 1'b1) begin errors++; $display("FAIL held_stall got %b exp 1", stall_s); end
        checks++; if (log_s.pc !== 64'd0) begin errors++; $display("FAIL stall_head got %h exp 0", log_s.pc); end
        pop = 1'b1;
        #1;
        checks++; if (stall_s !== 1'b0) begin errors++; $display("FAIL release_stall got %b exp 0", stall_s); end
        @(negedge clk);
        set_commit(1'b0, 0, '0, '0);
        for (int i = 1; i <= 8; i++) begin
            checks++; if (log_s.pc !== 64'(i)) begin errors++; $display("FAIL order_pc[%0d] got %h exp %h", i, log_s.pc, i); end
            @(negedge clk);
        end
        pop = 1'b0;
        checks++; if (empty_s !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", empty_s); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_commit(1'b1, 2, 64'(32'h100 + i), 64'h0);
            @(negedge clk);
        end
        set_commit(1'b1, 3, 64'h200, 64'h0);
        pop = 1'b1;
        #1;
        checks++; if (stall_s !== 1'b0) begin errors++; $display("FAIL b2b_stall got %b exp 0", stall_s); end
        @(negedge clk);
        pop = 1'b0;
        // Still full: another commit without a pop must stall.
        set_commit(1'b1, 2, 64'h300, 64'h0);
        #1;
        checks++; if (stall_s !== 1'b1) begin errors++; $display("FAIL b2b_still_full got %b exp 1", stall_s); end
        set_commit(1'b0, 0, '0, '0);
        pop = 1'b1;
        for (int i = 1; i < 8; i++) begin
            checks++; if (log_s.pc !== 64'(32'h100 + i)) begin errors++; $display("FAIL b2b_pc[%0d] got %h exp %h", i, log_s.pc, 32'h100 + i); end
            @(negedge clk);
        end
        checks++; if (log_s.pc !== 64'h200 || log_s.flags !== 4'b0010) begin
            errors++; $display("FAIL b2b_last got %h/%b exp 200/0010", log_s.pc, log_s.flags);
        end
        @(negedge clk);
        pop = 1'b0;
        checks++; if (empty_s !== 1'b1) begin errors++; $display("FAIL b2b_empty got %b exp 1", empty_s); end
    endtask

    task automatic test_drop();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            set_commit(1'b1, 4, 64'(i), 64'h0);
            #1;
            checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL drop_stall[%0d] got %b exp 0", i, stall_d); end
            @(negedge clk);
        end
        set_commit(1'b0, 0, '0, '0);
        checks++; if (dropped_d !== 32'd4) begin errors++; $display("FAIL dropped_count got %0d exp 4", dropped_d); end
        checks++; if (empty_d !== 1'b0) begin errors++; $display("FAIL drop_nonempty got %b exp 0", empty_d); end
        pop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (log_d.pc !== 64'(i) || log_d.flags !== 4'b0001) begin
                errors++; $display("FAIL drop_pc[%0d] got %h/%b exp %h/0001", i, log_d.pc, log_d.flags, i);
            end
            @(negedge clk);
        end
        pop = 1'b0;
    endtask

    // Runs after test_drop: 5 records queued, dropped_o = 4.
    task automatic test_flush();
        flush = 1'b1;
        pop   = 1'b1;
        set_commit(1'b1, 4, 64'h500, 64'h0);
        #1;
        checks++; if (stall_s !== 1'b0) begin errors++; $display("FAIL flush_stall got %b exp 0", stall_s); end
        @(negedge clk);
        flush = 1'b0;
        pop   = 1'b0;
        set_commit(1'b0, 0, '0, '0);
        checks++; if (empty_d !== 1'b1) begin errors++; $display("FAIL flush_empty got %b exp 1", empty_d); end
        checks++; if (dropped_d !== 32'd4) begin errors++; $display("FAIL flush_dropped got %0d exp 4", dropped_d); end
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        checks++; if (empty_d !== 1'b1) begin errors++; $display("FAIL underflow_empty got %b exp 1", empty_d); end
        set_commit(1'b1, 1, 64'h600, 64'h604);
        @(negedge clk);
        set_commit(1'b0, 0, '0, '0);
        checks++; if (empty_d !== 1'b0 || log_d.pc !== 64'h600) begin
            errors++; $display("FAIL post_flush_push got empty=%b pc=%h exp 0/600", empty_d, log_d.pc);
        end
        @(negedge clk);
        checks++; if (log_d.pc !== 64'h600) begin errors++; $display("FAIL post_flush_hold got %h exp 600", log_d.pc); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_commit(1'b1, 1, 64'(i), 64'h0);
            @(negedge clk);
        end
        set_commit(1'b1, 1, 64'd8, 64'h0);
        #1;
        checks++; if (stall_s !== 1'b1) begin errors++; $display("FAIL pre_reset_stall got %b exp 1", stall_s); end
        rst = 1'b1;
        #1;
        checks++; if (stall_s !== 1'b0) begin errors++; $display("FAIL reset_stall_drop got %b exp 0", stall_s); end
        @(negedge clk);
        rst = 1'b0;
        set_commit(1'b0, 0, '0, '0);
        checks++; if (empty_s !== 1'b1) begin errors++; $display("FAIL reset_mid_empty got %b exp 1", empty_s); end
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        pop   = 1'b0;
        set_commit(1'b0, 0, '0, '0);
        test_reset();
        test_branch();
        test_priority();
        test_full_stall();
        test_back_to_back();
        test_drop();
        test_flush();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
